// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding and decode helpers
// used both by md_unit and by the pipeline hazard controller.
package md_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5,
      MD_MADD  = 3'd6,
      MD_MSUB  = 3'd7
   } md_op_e;

   // Ops that occupy the unit for a multi-cycle countdown.
   function automatic logic is_md_long(input logic [2:0] op);
      case (md_op_e'(op))
         MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD, MD_MSUB: return 1'b1;
         default:                                              return 1'b0;
      endcase
   endfunction

   function automatic logic is_md_div(input logic [2:0] op);
      return (md_op_e'(op) == MD_DIV) || (md_op_e'(op) == MD_DIVU);
   endfunction

   // mfhi/mflo and any md issue must hold while the unit is busy or being started.
   function automatic logic md_stall(input logic uses_hilo, input logic busy,
                                     input logic start);
      return uses_hilo && (busy || start);
   endfunction

endpackage

// File: rtl/md_divider.sv
// Combinational signed/unsigned divider with MIPS-style divide-by-zero and
// most-negative / -1 overflow results.
module md_divider
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             is_signed,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic             neg_dividend;
   logic             neg_divisor;
   logic [WIDTH-1:0] mag_dividend;
   logic [WIDTH-1:0] mag_divisor;
   logic [WIDTH-1:0] mag_quo;
   logic [WIDTH-1:0] mag_rem;

   // Divide magnitudes, then restore signs: quotient truncates toward zero,
   // remainder follows the dividend.
   assign neg_dividend = is_signed && dividend[WIDTH-1];
   assign neg_divisor  = is_signed && divisor[WIDTH-1];
   assign mag_dividend = neg_dividend ? (~dividend + 1'b1) : dividend;
   assign mag_divisor  = neg_divisor  ? (~divisor + 1'b1)  : divisor;

   always_comb begin
      mag_quo = '0;
      mag_rem = '0;
      if (mag_divisor != '0) begin
         mag_quo = mag_dividend / mag_divisor;
         mag_rem = mag_dividend % mag_divisor;
      end
   end

   always_comb begin
      quotient  = (neg_dividend ^ neg_divisor) ? (~mag_quo + 1'b1) : mag_quo;
      remainder = neg_dividend ? (~mag_rem + 1'b1) : mag_rem;
      if (divisor == '0) begin
         quotient  = '1;
         remainder = dividend;
      end else if (is_signed && dividend == MOST_NEG && divisor == '1) begin
         quotient  = MOST_NEG;
         remainder = '0;
      end
   end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit holding HI/LO; results are computed at issue and
// committed to HI/LO after a fixed per-op-class busy countdown.
module md_unit
   import md_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   logic [WIDTH-1:0]   hi_reg;
   logic [WIDTH-1:0]   lo_reg;
   logic               busy_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [WIDTH-1:0]   pend_hi_reg;
   logic [WIDTH-1:0]   pend_lo_reg;

   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0] prod_u;
   logic [2*WIDTH-1:0] result_next;
   logic [WIDTH-1:0]   div_quo;
   logic [WIDTH-1:0]   div_rem;
   logic [CNT_W-1:0]   cycles_next;

   assign acc    = {hi_reg, lo_reg};
   assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
   assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

   md_divider #(
      .WIDTH(WIDTH)
   ) u_divider (
      .dividend (a),
      .divisor  (b),
      .is_signed(md_op_e'(op) == MD_DIV),
      .quotient (div_quo),
      .remainder(div_rem)
   );

   // HI/LO cannot change while busy, so accumulating against the issue-time
   // value gives the same answer as accumulating at completion.
   always_comb begin
      result_next = acc;
      case (md_op_e'(op))
         MD_MULT:          result_next = prod_s;
         MD_MULTU:         result_next = prod_u;
         MD_MADD:          result_next = acc + prod_s;
         MD_MSUB:          result_next = acc - prod_s;
         MD_DIV, MD_DIVU:  result_next = {div_rem, div_quo};
         default:          result_next = acc;
      endcase
   end

   assign cycles_next = is_md_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_reg      <= '0;
         lo_reg      <= '0;
         busy_reg    <= 1'b0;
         cnt_reg     <= '0;
         pend_hi_reg <= '0;
         pend_lo_reg <= '0;
      end else if (busy_reg) begin
         cnt_reg <= cnt_reg - 1'b1;
         if (cnt_reg == CNT_W'(1)) begin
            hi_reg   <= pend_hi_reg;
            lo_reg   <= pend_lo_reg;
            busy_reg <= 1'b0;
         end
      end else if (start) begin
         if (is_md_long(op)) begin
            pend_hi_reg <= result_next[2*WIDTH-1:WIDTH];
            pend_lo_reg <= result_next[WIDTH-1:0];
            cnt_reg     <= cycles_next;
            busy_reg    <= 1'b1;
         end else if (md_op_e'(op) == MD_MTHI) begin
            hi_reg <= a;
         end else if (md_op_e'(op) == MD_MTLO) begin
            lo_reg <= a;
         end
      end
   end

   assign busy = busy_reg;
   assign hi   = hi_reg;
   assign lo   = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus randomized ops against
// an arithmetic reference model of HI/LO.
module tb_md_unit;
   import md_pkg::*;

   localparam int W     = 32;
   localparam int MUL_N = 5;
   localparam int DIV_N = 10;

   logic          clk;
   logic          reset;
   logic          start;
   logic [2:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   logic [W-1:0]  hi_m;
   logic [W-1:0]  lo_m;
   int            errors;
   int            checks;

   md_unit #(
      .WIDTH(W),
      .MUL_CYCLES(MUL_N),
      .DIV_CYCLES(DIV_N)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .start(start),
      .op   (op),
      .a    (a),
      .b    (b),
      .busy (busy),
      .hi   (hi),
      .lo   (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference model: plain 64-bit and int arithmetic from the ISA rules.
   task automatic model(input logic [2:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb);
      longint      p;
      logic [63:0] acc;
      logic [63:0] r;
      int          sa;
      int          sb;
      acc = {hi_m, lo_m};
      p   = longint'($signed(ma)) * longint'($signed(mb));
      sa  = ma;
      sb  = mb;
      case (mop)
         3'd0: r = p;
         3'd1: r = {32'b0, ma} * {32'b0, mb};
         3'd6: r = acc + p;
         3'd7: r = acc - p;
         3'd2, 3'd3: begin
            if (mb == 0) r = {ma, 32'hFFFF_FFFF};
            else if (mop == 3'd2 && ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF)
               r = {32'h0, 32'h8000_0000};
            else if (mop == 3'd2) r = {32'(sa % sb), 32'(sa / sb)};
            else r = {ma % mb, ma / mb};
         end
         3'd4: r = {ma, lo_m};
         default: r = {hi_m, ma};
      endcase
      hi_m = r[63:32];
      lo_m = r[31:0];
   endtask

   // Called at a falling edge; returns at the falling edge where busy is low again.
   task automatic do_op(input string tag, input logic [2:0] o, input logic [W-1:0] xa,
                        input logic [W-1:0] xb, input bit inject);
      int n;
      int exp_n;
      start = 1'b1; op = o; a = xa; b = xb;
      @(negedge clk);
      start = 1'b0;
      exp_n = (o == 3'd4 || o == 3'd5) ? 0 : ((o == 3'd2 || o == 3'd3) ? DIV_N : MUL_N);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         if (inject && n == 2) begin
            start = 1'b1; op = 3'd4; a = 32'd9;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      model(o, xa, xb);
      check({tag, ".busy_cycles"}, 64'(n), 64'(exp_n));
      check({tag, ".hilo"}, {hi, lo}, {hi_m, lo_m});
      $display("op=%0d a=%h b=%h busy_cycles=%0d hi=%h lo=%h", o, xa, xb, n, hi, lo);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      hi_m = '0;
      lo_m = '0;
      reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      check("reset.busy", 64'(busy), 64'd0);
      check("reset.hilo", {hi, lo}, 64'd0);
      reset = 1'b0;

      do_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
      check("mult_neg.const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
      do_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
      check("div_neg.const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      do_op("divu_zero", 3'd3, 32'd7, 32'd0, 1'b0);
      check("divu_zero.const", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
      do_op("mthi", 3'd4, 32'd5, 32'd0, 1'b0);
      do_op("mtlo", 3'd5, 32'hFFFF_FFFF, 32'd0, 1'b0);
      do_op("madd_carry", 3'd6, 32'd1, 32'd1, 1'b0);
      check("madd_carry.const", {hi, lo}, 64'h0000_0006_0000_0000);
      do_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      check("multu_max.const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check("div_ovf.const", {hi, lo}, 64'h0000_0000_8000_0000);
      do_op("div_zero", 3'd2, 32'hFFFF_FFF0, 32'd0, 1'b0);
      do_op("msub", 3'd7, 32'd3, 32'hFFFF_FFFE, 1'b0);

      // Reset during busy abandons the operation.
      start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      hi_m = '0; lo_m = '0;
      check("rst_mid.busy", 64'(busy), 64'd0);
      check("rst_mid.hilo", {hi, lo}, 64'd0);
      repeat (MUL_N + 2) @(negedge clk);
      check("rst_mid.no_commit", {hi, lo}, 64'd0);
      $display("reset mid-op: busy=%0d hi=%h lo=%h", busy, hi, lo);

      for (int i = 0; i < 40; i++) begin
         logic [2:0]   ro;
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ro = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = '0;
            1: begin ra = 32'h8000_0000; rb = '1; end
            2: rb = 32'($urandom_range(1, 9));
            default: ;
         endcase
         do_op($sformatf("rand%0d", i), ro, ra, rb, ($urandom_range(0, 3) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
